// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, state/word types, Rcon and GF(2^8) helpers.
// Also used by round_inv for its InvMixColumns datapath.
package aes_pkg;

    localparam int unsigned NR = 10;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;
    typedef logic [7:0]   byte_t;

    function automatic byte_t rcon(input logic [3:0] c);
        byte_t r;
        case (c)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t mul9(input byte_t b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic byte_t mul11(input byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic byte_t mul13(input byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic byte_t mul14(input byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p = 8'h00;
        byte_t x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as the S-box requires
    function automatic byte_t gf_inv(input byte_t a);
        byte_t t = a;
        byte_t r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            t = gf_mul(t, t);
            r = gf_mul(r, t);
        end
        return r;
    endfunction

    function automatic word_t inv_mix_col(input word_t w);
        byte_t a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3),
                mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
                mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3),
                mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3)};
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
    endfunction

endpackage

// File: rtl/sbox.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    byte_t inv;

    always_comb begin
        inv  = gf_inv(din);
        dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/key_sched.sv
// Iterative AES-128 key expansion into an 11-entry round-key file with a registered read port.
// Optional KEY_SCHED_INV_MIX_EN stores rk[1..9] after InvMixColumns (equivalent inverse cipher).
module key_sched
    import aes_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic [3:0]   rd_idx,
    output logic         busy,
    output logic         ready,
    output logic [127:0] rk_out
);

    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    state_t     prev_q;
    state_t     rk_q [NR+1];
    state_t     rk_out_q;

    word_t  w0, w1, w2, w3, rot, sub, n0, n1, n2, n3;
    state_t next_key, wr_key, rd_key;

    assign {w0, w1, w2, w3} = prev_q;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sub
        sbox u_sbox (
            .din  (rot[8*i +: 8]),
            .dout (sub[8*i +: 8])
        );
    end

    assign n0       = w0 ^ sub ^ {rcon(cnt_q), 24'h0};
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

`ifdef KEY_SCHED_INV_MIX_EN
    // The running register keeps the raw key; only the stored copy is transformed.
    assign wr_key = (cnt_q == LAST) ? next_key : inv_mix_columns(next_key);
`else
    assign wr_key = next_key;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (key_load) begin
            state_d = StExpand;
            cnt_d   = 4'd1;
        end else if (state_q == StExpand) begin
            if (cnt_q == LAST) begin
                state_d = StDone;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
        busy  = (state_q == StExpand);
        ready = (state_q == StDone);
    end

    always_comb begin
        rd_key = '0;
        if (ready && rd_idx <= LAST) rd_key = rk_q[rd_idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q   <= '0;
            rk_out_q <= '0;
            for (int unsigned i = 0; i <= NR; i++) rk_q[i] <= '0;
        end else begin
            if (key_load) begin
                prev_q   <= key_in;
                rk_q[0]  <= key_in;
            end else if (state_q == StExpand) begin
                prev_q      <= next_key;
                rk_q[cnt_q] <= wr_key;
            end
            rk_out_q <= rd_key;
        end
    end

    assign rk_out = rk_out_q;

endmodule
